// File: rtl/regfile_sequencer.sv
// Serial micro-sequencer driving an 8x16 register file with one combinational read port.
// Zero/carry flags are built only when REGSEQ_FLAGS_EN is defined; otherwise they are tied low.
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_en,
  output logic              done,
  output logic              busy,
  output logic              flag_z,
  output logic              flag_c,
  output logic [1:0]        fsm_state
);

  // Handshake: an instruction transfers on a rising edge with instr_valid && instr_ready.
  // instr_ready is high only in IDLE; valid seen while not ready is dropped, never queued.

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH_A = 2'd1,
    FETCH_B = 2'd2,
    WRITE   = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] src_b_q;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] alu_res;

  assign instr_ready = (state == IDLE);
  assign busy        = (state != IDLE);
  assign fsm_state   = state;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          if (opcode == OP_NOP || opcode == OP_LDI) next_state = WRITE;
          else                                     next_state = FETCH_A;
        end
      end
      FETCH_A: next_state = (op_q == OP_MOV) ? WRITE : FETCH_B;
      FETCH_B: next_state = WRITE;
      WRITE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // In FETCH_B the read port is already addressed at src_b, so rf_read_data is opB.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = op_a + rf_read_data;
      OP_SUB:  alu_res = op_a - rf_read_data;
      OP_AND:  alu_res = op_a & rf_read_data;
      OP_OR:   alu_res = op_a | rf_read_data;
      OP_XOR:  alu_res = op_a ^ rf_read_data;
      default: alu_res = '0;
    endcase
  end

  // Write-port outputs are loaded on the edge that enters WRITE so they are valid for its whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q          <= '0;
      dst_q         <= '0;
      src_b_q       <= '0;
      op_a          <= '0;
      rf_read_addr  <= '0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
      rf_write_en   <= 1'b0;
      done          <= 1'b0;
    end else begin
      rf_write_addr <= '0;
      rf_write_data <= '0;
      rf_write_en   <= 1'b0;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            op_q    <= opcode;
            dst_q   <= dst;
            src_b_q <= src_b;
            if (opcode == OP_NOP || opcode == OP_LDI) begin
              rf_write_addr <= dst;
              rf_write_data <= (opcode == OP_LDI) ? imm : '0;
              rf_write_en   <= (opcode == OP_LDI);
              done          <= 1'b1;
            end else begin
              rf_read_addr <= src_a;
            end
          end
        end
        FETCH_A: begin
          op_a <= rf_read_data;
          if (op_q == OP_MOV) begin
            rf_write_addr <= dst_q;
            rf_write_data <= rf_read_data;
            rf_write_en   <= 1'b1;
            done          <= 1'b1;
          end else begin
            rf_read_addr <= src_b_q;
          end
        end
        FETCH_B: begin
          rf_write_addr <= dst_q;
          rf_write_data <= alu_res;
          rf_write_en   <= 1'b1;
          done          <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef REGSEQ_FLAGS_EN
  logic alu_c;
  logic pend_z;
  logic pend_c;

  // A wrapped sum is smaller than either addend exactly when the add carried out.
  always_comb begin
    alu_c = 1'b0;
    if (op_q == OP_ADD)      alu_c = (alu_res < op_a);
    else if (op_q == OP_SUB) alu_c = (op_a < rf_read_data);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_z <= 1'b0;
      pend_c <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      if (state == FETCH_B) begin
        pend_z <= (alu_res == '0);
        pend_c <= alu_c;
      end
      if (state == WRITE && op_q >= OP_ADD) begin
        flag_z <= pend_z;
        flag_c <= pend_c;
      end
    end
  end
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural 8x16 register file, vector table, random phase, reset abort.
module tb_regfile_sequencer;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

`ifdef REGSEQ_FLAGS_EN
  localparam bit FLAGS_ON = 1'b1;
`else
  localparam bit FLAGS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [2:0]  opcode = '0;
  logic [2:0]  dst = '0;
  logic [2:0]  src_a = '0;
  logic [2:0]  src_b = '0;
  logic [15:0] imm = '0;
  logic [2:0]  rf_read_addr;
  logic [15:0] rf_read_data;
  logic [2:0]  rf_write_addr;
  logic [15:0] rf_write_data;
  logic        rf_write_en;
  logic        done;
  logic        busy;
  logic        flag_z;
  logic        flag_c;
  logic [1:0]  fsm_state;

  regfile_sequencer #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .dst(dst), .src_a(src_a), .src_b(src_b), .imm(imm),
    .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
    .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data), .rf_write_en(rf_write_en),
    .done(done), .busy(busy), .flag_z(flag_z), .flag_c(flag_c), .fsm_state(fsm_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // register file seen by the DUT; shares the sequencer reset
  logic [15:0] rf [8];
  assign rf_read_data = rf[rf_read_addr];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= '0;
    end else if (rf_write_en) begin
      rf[rf_write_addr] <= rf_write_data;
    end
  end

  // reference state
  logic [15:0] exp_rf [8];
  logic        exp_z;
  logic        exp_c;
  logic [19:0] exp_q[$];   // {addr[19:17], write_en[16], data[15:0]}
  logic [19:0] exp_e;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    if (op == OP_NOP || op == OP_LDI) return 1;
    if (op == OP_MOV) return 2;
    return 3;
  endfunction

  // scoreboard: pop one expected write per retirement
  always @(negedge clk) begin
    if (!reset) begin
      if (rf_write_en) check("write_en_implies_done", {31'b0, done}, 32'd1);
      if (done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: done=1 with empty expected queue at %0t", $time);
        end else begin
          exp_e = exp_q.pop_front();
          check("write_en", {31'b0, rf_write_en}, {31'b0, exp_e[16]});
          if (exp_e[16]) begin
            check("write_addr", {29'b0, rf_write_addr}, {29'b0, exp_e[19:17]});
            check("write_data", {16'b0, rf_write_data}, {16'b0, exp_e[15:0]});
          end
        end
      end
    end
  end

  // driver: called at a negedge with the DUT in IDLE; holds valid high with junk while busy
  task automatic issue(input logic [2:0] op, input logic [2:0] d, input logic [2:0] a,
                       input logic [2:0] b, input logic [15:0] im,
                       input logic [15:0] exp_data, input logic ez, input logic ec);
    int  cyc;
    bit  seen;
    bit  ready_bad;
    int  lat;
    lat = lat_of(op);
    instr_valid = 1'b1;
    opcode = op; dst = d; src_a = a; src_b = b; imm = im;
    exp_q.push_back({d, (op != OP_NOP), exp_data});
    @(posedge clk);
    #1;
    opcode = OP_LDI;
    dst    = 3'($urandom_range(0, 7));
    imm    = 16'($urandom_range(0, 16'hFFFF));
    cyc = 0; seen = 0; ready_bad = 0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (instr_ready) ready_bad = 1;
      if (done) seen = 1;
    end
    instr_valid = 1'b0;
    if (!seen) $display("FAIL retire_timeout: op %0d never retired within 20 cycles", op);
    check("latency", seen ? cyc : 32'hFFFF_FFFF, lat);
    check("ready_low_while_busy", {31'b0, ready_bad}, 32'd0);
    if (op != OP_NOP) exp_rf[d] = exp_data;
    exp_z = ez;
    exp_c = ec;
    @(negedge clk);
    check("flag_z", {31'b0, flag_z}, {31'b0, FLAGS_ON & exp_z});
    check("flag_c", {31'b0, flag_c}, {31'b0, FLAGS_ON & exp_c});
    check("ready_after_retire", {31'b0, instr_ready}, 32'd1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  d;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [15:0] im;
    logic [15:0] exp_data;
    logic        ez;
    logic        ec;
  } vec_t;

  vec_t vecs [12];

  task automatic run_random(input int n);
    logic [2:0]  op, d, a, b;
    logic [15:0] im, av, bv, res;
    logic [16:0] wide;
    logic        z, c;
    for (int i = 0; i < n; i++) begin
      op = 3'($urandom_range(0, 7));
      d  = 3'($urandom_range(0, 7));
      a  = 3'($urandom_range(0, 7));
      b  = 3'($urandom_range(0, 7));
      im = 16'($urandom_range(0, 16'hFFFF));
      av = exp_rf[a];
      bv = exp_rf[b];
      z = exp_z; c = exp_c; res = '0;
      case (op)
        OP_LDI: res = im;
        OP_MOV: res = av;
        OP_ADD: begin wide = {1'b0, av} + {1'b0, bv}; res = wide[15:0]; c = wide[16]; end
        OP_SUB: begin res = av - bv; c = (av < bv); end
        OP_AND: begin res = av & bv; c = 1'b0; end
        OP_OR:  begin res = av | bv; c = 1'b0; end
        OP_XOR: begin res = av ^ bv; c = 1'b0; end
        default: res = '0;
      endcase
      if (op >= OP_ADD) z = (res == 16'h0000);
      issue(op, d, a, b, im, res, z, c);
    end
  endtask

  initial begin
    vecs[0]  = '{OP_LDI, 3'd3, 3'd0, 3'd0, 16'h1234, 16'h1234, 1'b0, 1'b0};
    vecs[1]  = '{OP_LDI, 3'd1, 3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[2]  = '{OP_LDI, 3'd2, 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0, 1'b0};
    vecs[3]  = '{OP_ADD, 3'd4, 3'd1, 3'd2, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vecs[4]  = '{OP_SUB, 3'd5, 3'd2, 3'd1, 16'h0000, 16'h0002, 1'b0, 1'b1};
    vecs[5]  = '{OP_MOV, 3'd0, 3'd3, 3'd0, 16'h0000, 16'h1234, 1'b0, 1'b1};
    vecs[6]  = '{OP_XOR, 3'd3, 3'd3, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[7]  = '{OP_AND, 3'd6, 3'd1, 3'd5, 16'h0000, 16'h0002, 1'b0, 1'b0};
    vecs[8]  = '{OP_OR,  3'd7, 3'd4, 3'd2, 16'h0000, 16'h0001, 1'b0, 1'b0};
    vecs[9]  = '{OP_ADD, 3'd7, 3'd7, 3'd7, 16'h0000, 16'h0002, 1'b0, 1'b0};
    vecs[10] = '{OP_SUB, 3'd6, 3'd4, 3'd4, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[11] = '{OP_NOP, 3'd5, 3'd0, 3'd0, 16'hABCD, 16'h0000, 1'b1, 1'b0};

    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    exp_z = 1'b0;
    exp_c = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'b0, instr_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_write_en", {31'b0, rf_write_en}, 32'd0);
    check("rst_read_addr", {29'b0, rf_read_addr}, 32'd0);
    check("rst_write_addr", {29'b0, rf_write_addr}, 32'd0);
    check("rst_write_data", {16'b0, rf_write_data}, 32'd0);
    check("rst_flags", {30'b0, flag_z, flag_c}, 32'd0);
    check("rst_state", {30'b0, fsm_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++)
      issue(vecs[i].op, vecs[i].d, vecs[i].a, vecs[i].b, vecs[i].im,
            vecs[i].exp_data, vecs[i].ez, vecs[i].ec);
    check("r3_after_ldi_mov_xor", {16'b0, rf[3]}, 32'h0000);
    check("r0_after_mov", {16'b0, rf[0]}, 32'h1234);

    run_random(24);

    // abort an ADD with reset during FETCH_B
    instr_valid = 1'b1;
    opcode = OP_ADD; dst = 3'd4; src_a = 3'd1; src_b = 3'd2; imm = '0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("abort_in_fetch_a", {30'b0, fsm_state}, 32'd1);
    @(negedge clk);
    check("abort_in_fetch_b", {30'b0, fsm_state}, 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("abort_write_en", {31'b0, rf_write_en}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_state_idle", {30'b0, fsm_state}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) exp_rf[i] = '0;
    exp_z = 1'b0;
    exp_c = 1'b0;
    @(negedge clk);
    check("abort_ready_after", {31'b0, instr_ready}, 32'd1);
    check("abort_done_after", {31'b0, done}, 32'd0);
    check("abort_write_en_after", {31'b0, rf_write_en}, 32'd0);
    check("abort_flags_cleared", {30'b0, flag_z, flag_c}, 32'd0);

    issue(OP_LDI, 3'd2, 3'd0, 3'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0);
    issue(OP_MOV, 3'd5, 3'd2, 3'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0);

    // final register file contents against the reference model
    for (int i = 0; i < 8; i++) check($sformatf("rf_final_r%0d", i), {16'b0, rf[i]}, {16'b0, exp_rf[i]});
    check("exp_queue_drained", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
Micro-sequencer that sits directly upstream of the 8x16 register file and is its only master. It accepts one register-level instruction at a time over a valid/ready handshake. Because the register file has a single combinational read port, operands are fetched serially. The result is written back through the file's single write port.

Parameters:
DATA_W, 16, register/data width; must match the register file.
ADDR_W, 3, register address width (8 registers).

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
instr_valid  in  1  instruction fields valid this cycle.
instr_ready  out  1  sequencer can accept an instruction.
opcode  in  3  0 NOP, 1 LDI, 2 MOV, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR.
dst  in  ADDR_W  destination register.
src_a  in  ADDR_W  first source register.
src_b  in  ADDR_W  second source register (binary ops only).
imm  in  DATA_W  immediate value (LDI only).
rf_read_addr  out  ADDR_W  to register file read_addr.
rf_read_data  in  DATA_W  from register file data_out; combinational in rf_read_addr.
rf_write_addr  out  ADDR_W  to register file write_addr.
rf_write_data  out  DATA_W  to register file data_in.
rf_write_en  out  1  to register file write_en.
done  out  1  one-cycle pulse when an instruction retires.
busy  out  1  high whenever the state is not IDLE.
flag_z  out  1  zero flag (optional feature).
flag_c  out  1  carry/borrow flag (optional feature).

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high, named reset; clock named clk.
- Reset values: state IDLE, instr_ready=1, busy=0, done=0, rf_write_en=0, rf_read_addr=0, rf_write_addr=0, rf_write_data=0, flag_z=0, flag_c=0, all internal latches 0.
- FSM states are IDLE, FETCH_A, FETCH_B, WRITE.
- IDLE: instr_ready=1. When instr_valid=1, latch opcode, dst, src_a, src_b and imm at the rising edge.
  - LDI or NOP goes to WRITE.
  - MOV goes to FETCH_A.
  - ADD through XOR go to FETCH_A.
- FETCH_A: rf_read_addr=src_a latch; capture rf_read_data into opA at the edge. MOV then goes to WRITE; binary ops go to FETCH_B.
- FETCH_B: rf_read_addr=src_b latch; capture rf_read_data into opB at the edge, then go to WRITE.
- WRITE: rf_write_addr=dst and rf_write_data=result. rf_write_en=1 for every opcode except NOP (NOP gives 0). done=1. Next state is IDLE.
- Outside the fetch states, rf_read_addr holds its last driven value.
- rf_write_en, rf_write_addr, rf_write_data and done are registered outputs, asserted only while in WRITE.
- instr_ready=0 in every non-IDLE state. instr_valid is ignored while not ready and is not queued.
- Latency from the accept edge to the write edge: LDI/NOP 1 cycle, MOV 2 cycles, binary ops 3 cycles. Back-to-back throughput is one instruction per (latency+1) cycles.
- Results:
  - LDI gives imm; MOV gives opA.
  - ADD/SUB give opA±opB modulo 2^DATA_W.
  - AND/OR/XOR are bitwise.
- No hazard logic is needed. The write lands at the WRITE edge, and the next instruction's FETCH_A is at least 1 cycle later, so the new value is read.
- src_a==src_b, dst==src_a and dst==src_b are all legal; operands are captured before the write.
- Reset mid-operation: return to IDLE on the next edge. No write occurs after the reset edge, done is not asserted, and the aborted instruction is discarded.
- Reset asserted during WRITE: that edge's write still reaches the file, but the file shares reset so its contents clear anyway. The sequencer must not pulse done afterwards.

Optional Feature:
- Macro REGSEQ_FLAGS_EN.
- Defined: flag_z and flag_c are registered at the WRITE edge of ADD/SUB/AND/OR/XOR only; LDI/MOV/NOP leave them unchanged.
  - flag_z = (result==0).
  - ADD: flag_c = carry out of bit DATA_W-1.
  - SUB: flag_c = borrow, i.e. opA<opB unsigned.
  - Logic ops: flag_c = 0.
- Undefined: flag_z and flag_c are tied to 0 and no flag logic is synthesised.

Test Plan:
- Reset, then LDI dst=3 imm=0x1234 -> exactly 1 cycle after accept: rf_write_en=1, addr=3, data=0x1234, done=1; R3 reads 0x1234.
- LDI R1=0xFFFF, LDI R2=0x0001, ADD dst=4 a=1 b=2 -> R4=0x0000 with 3-cycle latency; with flags, flag_z=1 and flag_c=1.
- SUB dst=5 a=2 b=1 using the values above -> R5=0x0002; flags flag_z=0, flag_c=1 (borrow).
- MOV dst=0 a=3, then immediately XOR dst=3 a=3 b=0 -> R0=0x1234, R3=0x0000; instr_ready low on every non-IDLE cycle; instr_valid held high while busy is not double-accepted.
- Start ADD, assert reset during FETCH_B -> no rf_write_en pulse, no done, FSM back in IDLE, instr_ready=1 the cycle after reset deasserts.
- NOP accepted -> done=1 one cycle later, rf_write_en stays 0, flags unchanged.
